// File: rtl/sm83_mcycle.sv
// sm83_mcycle: machine-cycle bus sequencer for the sm83 core.
//
// Turns a single-cycle request from the control unit into a T1..T4 external bus
// cycle, with wait states inserted between T2 and T3. The wait states come from
// a static per-request count (wait_cfg, saturated to WAIT_MAX) and from ext_ready.
//
// Optional feature: define SM83_MCYCLE_TIMEOUT_EN to bound ready-stall waits to
// TIMEOUT_CYCLES. A timed-out read returns all-ones, and bus_err is flagged in T4.
// Without the macro, waits are unbounded and bus_err is constant 0.
//
// Ports:
//   clk, n_reset             clock, asynchronous active-low reset
//   start, mread, mwrite     request strobe and command (sampled in IDLE and T4)
//   ain, din, wait_cfg       request address, write data, static wait count
//   dout                     read-data latch
//   busy, done, bus_err      status (done/bus_err only during T4)
//   t1, t2, t3, t4, tw       one-hot T-state indicators
//   ext_adr, ext_dout        external address / write data
//   ext_din, ext_ready       external read data / ready (low = wait)
//   p_rd, n_rd, p_wr, n_wr   registered read/write strobes, true and complement
module sm83_mcycle #(
  parameter int unsigned ADR_WIDTH      = 16,
  parameter int unsigned WORD_SIZE      = 8,
  parameter int unsigned WAIT_MAX       = 3,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  localparam int unsigned WW            = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1)
) (
  input  logic                 clk,
  input  logic                 n_reset,
  input  logic                 start,
  input  logic                 mread,
  input  logic                 mwrite,
  input  logic [ADR_WIDTH-1:0] ain,
  input  logic [WORD_SIZE-1:0] din,
  input  logic [WW-1:0]        wait_cfg,
  output logic [WORD_SIZE-1:0] dout,
  output logic                 busy,
  output logic                 done,
  output logic                 bus_err,
  output logic                 t1,
  output logic                 t2,
  output logic                 t3,
  output logic                 t4,
  output logic                 tw,
  output logic [ADR_WIDTH-1:0] ext_adr,
  output logic [WORD_SIZE-1:0] ext_dout,
  input  logic [WORD_SIZE-1:0] ext_din,
  input  logic                 ext_ready,
  output logic                 p_rd,
  output logic                 n_rd,
  output logic                 p_wr,
  output logic                 n_wr
);

  typedef enum logic [2:0] {StIdle, StT1, StT2, StTw, StT3, StT4} state_e;

  state_e               state_q, state_d;
  logic [WW-1:0]        wc_q, wc_d, wait_sat;
  logic                 cmd_rd_q, cmd_rd_d, cmd_wr_q, cmd_wr_d;
  logic                 accept;
  logic [ADR_WIDTH-1:0] ext_adr_q;
  logic [WORD_SIZE-1:0] ext_dout_q, dout_q, rd_data;

  // Next-cycle values of the registered outputs.
  logic t1_d, t2_d, t3_d, t4_d, tw_d, busy_d, done_d, bus_err_d, p_rd_d, p_wr_d;
  logic t1_q, t2_q, t3_q, t4_q, tw_q, busy_q, done_q, bus_err_q, p_rd_q, p_wr_q;
  logic n_rd_q, n_wr_q;

`ifdef SM83_MCYCLE_TIMEOUT_EN
  localparam int unsigned TOW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  logic [TOW-1:0] to_cnt_q, to_cnt_d;
  logic           to_q, to_d;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT_CYCLES;
`endif

  assign wait_sat = (32'(wait_cfg) > WAIT_MAX) ? WW'(WAIT_MAX) : wait_cfg;

  // State register, request latches and wait counters.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q  <= StIdle;
      wc_q     <= '0;
      cmd_rd_q <= 1'b0;
      cmd_wr_q <= 1'b0;
`ifdef SM83_MCYCLE_TIMEOUT_EN
      to_cnt_q <= '0;
      to_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      wc_q     <= wc_d;
      cmd_rd_q <= cmd_rd_d;
      cmd_wr_q <= cmd_wr_d;
`ifdef SM83_MCYCLE_TIMEOUT_EN
      to_cnt_q <= to_cnt_d;
      to_q     <= to_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    wc_d     = wc_q;
    cmd_rd_d = cmd_rd_q;
    cmd_wr_d = cmd_wr_q;
    accept   = 1'b0;
`ifdef SM83_MCYCLE_TIMEOUT_EN
    to_cnt_d = to_cnt_q;
    to_d     = to_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StT1;
          accept  = 1'b1;
        end
      end
      StT1: begin
        state_d = StT2;
`ifdef SM83_MCYCLE_TIMEOUT_EN
        to_cnt_d = '0;
`endif
      end
      StT2, StTw: begin
        // Static waits drain first; ext_ready only matters once wc is zero.
        if (wc_q != '0) begin
          wc_d    = wc_q - WW'(1);
          state_d = StTw;
        end else if (!ext_ready) begin
          state_d = StTw;
`ifdef SM83_MCYCLE_TIMEOUT_EN
          // Only TW cycles stalled on ready count toward the limit.
          if (state_q == StTw) begin
            to_cnt_d = to_cnt_q + TOW'(1);
            if (to_cnt_q == TOW'(TIMEOUT_CYCLES - 1)) begin
              state_d = StT3;
              to_d    = 1'b1;
            end
          end
`endif
        end else begin
          state_d = StT3;
        end
      end
      StT3: state_d = StT4;
      StT4: begin
        if (start) begin
          state_d = StT1;
          accept  = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (accept) begin
      wc_d     = wait_sat;
      // Write wins when both are requested; neither means an internal cycle.
      cmd_wr_d = mwrite;
      cmd_rd_d = mread & ~mwrite;
`ifdef SM83_MCYCLE_TIMEOUT_EN
      to_d     = 1'b0;
`endif
    end
  end

  // Output decode of the next state; registered below so strobes never glitch.
  always_comb begin
    t1_d   = (state_d == StT1);
    t2_d   = (state_d == StT2);
    tw_d   = (state_d == StTw);
    t3_d   = (state_d == StT3);
    t4_d   = (state_d == StT4);
    busy_d = (state_d != StIdle);
    done_d = (state_d == StT4);
    p_rd_d = cmd_rd_d & (state_d inside {StT1, StT2, StTw, StT3});
    p_wr_d = cmd_wr_d & (state_d inside {StT2, StTw, StT3});
`ifdef SM83_MCYCLE_TIMEOUT_EN
    bus_err_d = (state_d == StT4) & to_d;
`else
    bus_err_d = 1'b0;
`endif
  end

`ifdef SM83_MCYCLE_TIMEOUT_EN
  assign rd_data = to_q ? '1 : ext_din;
`else
  assign rd_data = ext_din;
`endif

  // Registered outputs and data path.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      t1_q       <= 1'b0;
      t2_q       <= 1'b0;
      t3_q       <= 1'b0;
      t4_q       <= 1'b0;
      tw_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bus_err_q  <= 1'b0;
      p_rd_q     <= 1'b0;
      n_rd_q     <= 1'b1;
      p_wr_q     <= 1'b0;
      n_wr_q     <= 1'b1;
      ext_adr_q  <= '0;
      ext_dout_q <= '0;
      dout_q     <= '0;
    end else begin
      t1_q      <= t1_d;
      t2_q      <= t2_d;
      t3_q      <= t3_d;
      t4_q      <= t4_d;
      tw_q      <= tw_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      bus_err_q <= bus_err_d;
      p_rd_q    <= p_rd_d;
      n_rd_q    <= ~p_rd_d;
      p_wr_q    <= p_wr_d;
      n_wr_q    <= ~p_wr_d;
      if (accept) begin
        ext_adr_q  <= ain;
        ext_dout_q <= din;
      end
      if (state_q == StT3 && cmd_rd_q) begin
        dout_q <= rd_data;
      end
    end
  end

  assign t1       = t1_q;
  assign t2       = t2_q;
  assign t3       = t3_q;
  assign t4       = t4_q;
  assign tw       = tw_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign bus_err  = bus_err_q;
  assign p_rd     = p_rd_q;
  assign n_rd     = n_rd_q;
  assign p_wr     = p_wr_q;
  assign n_wr     = n_wr_q;
  assign ext_adr  = ext_adr_q;
  assign ext_dout = ext_dout_q;
  assign dout     = dout_q;

endmodule
